// File: rtl/rca24_share_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rca24_share_arbiter_if                                 |
// | Description : Request, shared-adder and response signal bundle for   |
// |               rca24_share_arbiter. The slave modport is the arbiter  |
// |               side; master is the requesters/adder/consumer side.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface rca24_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 24,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]       i_req_valid;
  logic [N_REQ-1:0]       o_req_ready;
  logic [N_REQ*WIDTH-1:0] i_req_a;
  logic [N_REQ*WIDTH-1:0] i_req_b;
  logic [WIDTH-1:0]       o_add_term1;
  logic [WIDTH-1:0]       o_add_term2;
  logic [WIDTH:0]         i_add_result;
  logic                   o_rsp_valid;
  logic                   i_rsp_ready;
  logic [IDW-1:0]         o_rsp_id;
  logic [WIDTH:0]         o_rsp_sum;
  logic                   o_busy;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_add_result, i_rsp_ready,
    output o_req_ready, o_add_term1, o_add_term2, o_rsp_valid, o_rsp_id,
           o_rsp_sum, o_busy
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_add_result, i_rsp_ready,
    input  o_req_ready, o_add_term1, o_add_term2, o_rsp_valid, o_rsp_id,
           o_rsp_sum, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/rca24_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rca24_share_arbiter                                    |
// | Description : Round-robin arbiter/sequencer time-sharing one external|
// |               ripple-carry adder among N_REQ requesters. Operands are|
// |               registered, held SETTLE_CYCLES cycles, then the adder  |
// |               result is captured and returned with the requester ID. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rca24_share_arbiter #(
  parameter int N_REQ         = 4,
  parameter int WIDTH         = 24,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDW           = 2
) (
  input wire logic             i_clk,
  input wire logic             i_rst,
  rca24_share_arbiter_if.slave bus
);

  // Counter only needs to reach SETTLE_CYCLES-1; keep at least one bit.
  localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNTW-1:0] c_cnt_load = CNTW'(SETTLE_CYCLES - 1);
  localparam logic [IDW-1:0]  c_last_id  = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_term1;
  logic [WIDTH-1:0] r_term2;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH:0]   r_rsp_sum;
  logic             r_rsp_valid;

  logic             w_gnt_found;
  logic [IDW-1:0]   w_gnt_idx;
  logic [IDW-1:0]   w_cand;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [N_REQ-1:0] w_req_ready;
  logic             w_accept;
  logic             w_rsp_fire;

  // Round-robin search starting at r_ptr, plus operand mux for the winner.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    w_op_a      = '0;
    w_op_b      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = IDW'((int'(r_ptr) + i) % N_REQ);
      if (!w_gnt_found && bus.i_req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt_idx == IDW'(k)) begin
        w_op_a = bus.i_req_a[k*WIDTH +: WIDTH];
        w_op_b = bus.i_req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready only in IDLE, only for the winner, never while reset is asserted.
  always_comb begin
    w_req_ready = '0;
    if ((r_state == ST_IDLE) && !i_rst && w_gnt_found) begin
      w_req_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign w_accept   = |w_req_ready;
  assign w_rsp_fire = r_rsp_valid & bus.i_rsp_ready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: accept -> settle countdown -> hold response.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)          w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_cnt == '0)       w_state_nxt = ST_RESP;
      ST_RESP:   if (w_rsp_fire)        w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand/response datapath and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_term1     <= '0;
      r_term2     <= '0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_term1  <= w_op_a;
            r_term2  <= w_op_b;
            r_rsp_id <= w_gnt_idx;
            r_cnt    <= c_cnt_load;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_rsp_sum   <= bus.i_add_result;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= (r_rsp_id == c_last_id) ? '0 : r_rsp_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_req_ready = w_req_ready;
  assign bus.o_add_term1 = r_term1;
  assign bus.o_add_term2 = r_term2;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_id    = r_rsp_id;
  assign bus.o_rsp_sum   = r_rsp_sum;
  assign bus.o_busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rca24_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_rca24_share_arbiter                                 |
// | Description : Directed self-checking bench for rca24_share_arbiter;  |
// |               the shared adder is modelled by a continuous add.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_rca24_share_arbiter;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;

  rca24_share_arbiter_if #(.N_REQ(4), .WIDTH(24), .IDW(2)) bus ();

  rca24_share_arbiter #(
    .N_REQ(4), .WIDTH(24), .SETTLE_CYCLES(2), .IDW(2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // External ripple-carry adder stand-in.
  assign bus.i_add_result = {1'b0, bus.o_add_term1} + {1'b0, bus.o_add_term2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used for interval measurements.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Wait for a grant, check it, then wait for and check the response.
  // Returns in the first RESP cycle.
  task automatic do_op(input int g, input logic [31:0] exp_sum, output int acc_cyc);
    int n;
    n = 0;
    while (bus.o_req_ready == 4'b0000 && n < 20) begin
      step();
      n++;
    end
    check("grant_wait", 32'(n < 20), 32'd1);
    check("grant_onehot", 32'(bus.o_req_ready), 32'(1 << g));
    acc_cyc = cyc;
    step();
    n = 1;
    while (!bus.o_rsp_valid && n < 20) begin
      check("ready_low_settle", 32'(bus.o_req_ready), 32'd0);
      step();
      n++;
    end
    check("latency", 32'(n), 32'd3);
    check("rsp_id", 32'(bus.o_rsp_id), 32'(g));
    check("rsp_sum", 32'(bus.o_rsp_sum), exp_sum);
  endtask

  initial begin
    int acc;
    int prev;
    int seen;
    n_tests = 0;
    n_fail  = 0;

    // 1. Reset values, then lone requester 2 with carry-out.
    rst              = 1'b1;
    bus.i_req_valid  = 4'b0100;
    bus.i_req_a      = '0;
    bus.i_req_b      = '0;
    bus.i_req_a[2*24 +: 24] = 24'hFFFFFF;
    bus.i_req_b[2*24 +: 24] = 24'h000001;
    bus.i_rsp_ready  = 1'b0;
    step();
    step();
    check("rst_ready_forced", 32'(bus.o_req_ready), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_rsp_sum", 32'(bus.o_rsp_sum), 32'd0);
    check("rst_rsp_id", 32'(bus.o_rsp_id), 32'd0);
    check("rst_term1", 32'(bus.o_add_term1), 32'd0);
    check("rst_term2", 32'(bus.o_add_term2), 32'd0);
    rst = 1'b0;
    #1;
    do_op(2, 32'h1000000, acc);
    check("t1_term1", 32'(bus.o_add_term1), 32'hFFFFFF);
    check("t1_term2", 32'(bus.o_add_term2), 32'h000001);
    bus.i_req_valid = 4'b0000;
    bus.i_rsp_ready = 1'b1;
    step();
    check("t1_idle_after", 32'(bus.o_busy), 32'd0);

    // 2. All four valid: 0,1,2,3,0,1 with one issue every 4 cycles.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.i_req_a[k*24 +: 24] = 24'(k);
      bus.i_req_b[k*24 +: 24] = 24'h000100;
    end
    bus.i_req_valid = 4'b1111;
    bus.i_rsp_ready = 1'b1;
    #1;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      do_op(i % 4, 32'h100 + 32'(i % 4), acc);
      if (i > 0) check("issue_interval", 32'(acc - prev), 32'd4);
      prev = acc;
    end

    // 3. Requesters 1 and 3 only, from ptr 0: 1,3,1,3.
    do_reset();
    bus.i_req_valid = 4'b1010;
    #1;
    do_op(1, 32'h101, acc);
    do_op(3, 32'h103, acc);
    do_op(1, 32'h101, acc);
    do_op(3, 32'h103, acc);
    step();

    // 4. Backpressure on the response channel (ptr is 0 here).
    bus.i_req_valid = 4'b0001;
    bus.i_req_a[0 +: 24] = 24'h123456;
    bus.i_req_b[0 +: 24] = 24'h111111;
    bus.i_rsp_ready = 1'b0;
    #1;
    do_op(0, 32'h234567, acc);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(bus.o_rsp_valid), 32'd1);
      check("bp_sum", 32'(bus.o_rsp_sum), 32'h234567);
      check("bp_id", 32'(bus.o_rsp_id), 32'd0);
      check("bp_ready_low", 32'(bus.o_req_ready), 32'd0);
      step();
    end
    bus.i_rsp_ready = 1'b1;
    #1;
    check("bp_c6_valid", 32'(bus.o_rsp_valid), 32'd1);
    step();
    bus.i_req_valid = 4'b0000;
    #1;
    check("bp_idle_busy", 32'(bus.o_busy), 32'd0);
    check("bp_idle_valid", 32'(bus.o_rsp_valid), 32'd0);

    // 5. Max operands on requester 1, then zeros on requester 2.
    bus.i_req_a[1*24 +: 24] = 24'hFFFFFF;
    bus.i_req_b[1*24 +: 24] = 24'hFFFFFF;
    bus.i_req_valid = 4'b0010;
    #1;
    do_op(1, 32'h1FFFFFE, acc);
    bus.i_req_a[2*24 +: 24] = 24'h000000;
    bus.i_req_b[2*24 +: 24] = 24'h000000;
    bus.i_req_valid = 4'b0100;
    #1;
    do_op(2, 32'h0, acc);

    // 6. Reset during SETTLE with requester 3 in flight.
    bus.i_req_a[3*24 +: 24] = 24'h000005;
    bus.i_req_b[3*24 +: 24] = 24'h000006;
    bus.i_req_valid = 4'b1000;
    #1;
    step();
    check("t6_grant3", 32'(bus.o_req_ready), 32'h8);
    step();
    bus.i_req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    check("t6_busy_settle", 32'(bus.o_busy), 32'd1);
    step();
    check("t6_busy", 32'(bus.o_busy), 32'd0);
    check("t6_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("t6_rsp_sum", 32'(bus.o_rsp_sum), 32'd0);
    check("t6_rsp_id", 32'(bus.o_rsp_id), 32'd0);
    check("t6_term1", 32'(bus.o_add_term1), 32'd0);
    check("t6_term2", 32'(bus.o_add_term2), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.o_rsp_valid) seen++;
    end
    check("t6_no_response", 32'(seen), 32'd0);
    bus.i_req_valid = 4'b1001;
    #1;
    check("t6_ptr0_grant", 32'(bus.o_req_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rca24_share_arbiter.md
# rca24_share_arbiter

Round-robin arbiter and sequencer that time-shares one external 24-bit ripple-carry adder (`ripple_carry_adder_24bit` instance) among N requesters. It accepts one operand pair at a time over a valid/ready handshake, drives the adder from registered operands, and waits a fixed number of cycles for the ripple chain to settle. It then captures the 25-bit result and returns it with the requester ID over a valid/ready response channel. It sits between the requesting datapath units and the shared adder netlist.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 24: operand width. Must match the adder instance.
- `SETTLE_CYCLES`, default 2: cycles the adder inputs are held before the result is sampled. Must be ≥1; 0 is illegal.
- `IDW`, default 2: width of the ID field, equal to clog2(N_REQ).

Ports:
- `i_clk` input 1: the single clock; all state updates on its rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_req_valid` input N_REQ: per-requester request valid.
- `o_req_ready` output N_REQ: per-requester accept strobe; at most one bit high.
- `i_req_a` input N_REQ*WIDTH: operand A; requester k occupies bits [k*WIDTH +: WIDTH].
- `i_req_b` input N_REQ*WIDTH: operand B; same packing as `i_req_a`.
- `o_add_term1` output WIDTH: registered operand A, driven to the adder.
- `o_add_term2` output WIDTH: registered operand B, driven to the adder.
- `i_add_result` input WIDTH+1: adder output.
- `o_rsp_valid` output 1: response valid.
- `i_rsp_ready` input 1: consumer accepts the response.
- `o_rsp_id` output IDW: index of the requester that owns the response.
- `o_rsp_sum` output WIDTH+1: captured sum, including carry-out.
- `o_busy` output 1: high whenever the state is not IDLE.

## Operation
State machine: IDLE → SETTLE → RESP → IDLE.

**IDLE**
- Combinational round-robin grant over `i_req_valid`. Priority order is ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
- `o_req_ready[g]` = 1 only for the granted g, only in IDLE, and only while `i_req_valid[g]` = 1.
- On the accept edge (valid & ready):
  - `o_add_term1` ← A[g] and `o_add_term2` ← B[g].
  - `o_rsp_id` ← g.
  - Settle counter ← SETTLE_CYCLES-1.
  - Go to SETTLE.
- With no valid request, the FSM stays in IDLE and the operand registers hold their values.

**SETTLE**
- The counter decrements each cycle.
- On the cycle the counter is 0: `o_rsp_sum` ← `i_add_result`, `o_rsp_valid` ← 1, go to RESP.

**RESP**
- `o_rsp_valid`, `o_rsp_id`, `o_rsp_sum` and the operand registers are held stable.
- On (`o_rsp_valid` & `i_rsp_ready`): `o_rsp_valid` ← 0, ptr ← (g+1) mod N_REQ, go to IDLE.

**Arithmetic and requester rules**
- The sum is whatever the adder produces; the block performs no arithmetic itself.
- Full 25-bit result; no saturation, no wrap handling.
- Requesters must hold valid and operands stable until ready. Dropping valid before ready is legal and cancels the request with no side effects.
- `o_req_ready` is all zeros in SETTLE and RESP. No new request is accepted in the same cycle as a response handshake.

## Timing
- Reset values (`i_rst` = 1 at an edge): state IDLE, ptr 0, counter 0, `o_rsp_valid` 0, `o_rsp_id` 0, `o_rsp_sum` 0, `o_add_term1` 0, `o_add_term2` 0, `o_busy` 0.
- `o_req_ready` is forced to 0 during any cycle with `i_rst` high.
- Reset mid-operation (in SETTLE or RESP): the in-flight operation is discarded, no response is issued, and ptr returns to 0.
- Latency: accept edge at cycle t → `o_rsp_valid` high from cycle t+SETTLE_CYCLES+1.
- With defaults: accept at t, `o_rsp_valid` at t+3.
- Minimum issue interval: SETTLE_CYCLES+2 cycles per operation, assuming `i_rsp_ready` is held high.
- `o_rsp_sum` is sampled exactly SETTLE_CYCLES full cycles after the operands change. The required slack is therefore SETTLE_CYCLES × clock period ≥ the adder's worst-case ripple delay.
- Pointer wrap: after a grant to N_REQ-1, ptr = 0.
- Simultaneous valids are resolved purely by ptr order, with no starvation. Each valid requester is served within N_REQ operations.

## Test plan
1. Reset, then requester 2 only: A=0xFFFFFF, B=0x000001 → `o_req_ready` = 4'b0100 for one cycle; `o_rsp_valid` high 3 cycles later; `o_rsp_sum` = 0x1000000; `o_rsp_id` = 2.
2. All four valid continuously, `i_rsp_ready` = 1 → grant order 0,1,2,3,0,1; one response every 4 cycles. Operands A=k, B=0x100 → sums 0x100..0x103.
3. `i_req_valid` = 4'b1010 held, starting from ptr 0 → grants 1,3,1,3; requesters 0 and 2 are never readied.
4. Backpressure: response pending with `i_rsp_ready` = 0 for 5 cycles → `o_rsp_valid`, `o_rsp_sum` and `o_rsp_id` stable; `o_req_ready` = 0 throughout. Accept on cycle 6 → IDLE on the next cycle.
5. Max operands A=B=0xFFFFFF → `o_rsp_sum` = 0x1FFFFFE. Then A=B=0 → `o_rsp_sum` = 0x0000000.
6. `i_rst` pulsed during SETTLE with request 3 in flight → no `o_rsp_valid`; all outputs at reset values. The next request from 0 and 3 together grants 0 (ptr = 0).
